// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared types and constants for the two-port RAM arbiter.
//   arb_state_t : arbiter FSM states
//   ram_req_t   : one captured RAM access (we, addr, wdata, wmask)
//   RAM_RD_LAT  : RAM read latency in cycles (rden -> rdata)
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_RD_LAT = 1;

  // Owner ids: requester 0 is the RISC-V core, requester 1 the PIM/DMA port.
  localparam logic OWNER_CORE  = 1'b0;
  localparam logic OWNER_ACCEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wmask;
  } ram_req_t;

endpackage

// File: rtl/ram_arb_priority.sv
// ram_arb_priority
// Winner select for the two requesters plus the saturating starvation
// counter. The core wins by default; the accelerator wins when it is the only
// requester or when it has watched STARVE_LIMIT core grants go by.
//   clk, reset_n  : clock, async active-low reset
//   arb_en        : arbiter is in IDLE this cycle (grant decision is taken)
//   req0, req1    : sampled requests
//   grant_valid   : at least one request present
//   grant_id      : owner id of the winner (OWNER_CORE / OWNER_ACCEL)
//   starve_cnt    : core grants seen while req1 was waiting
module ram_arb_priority
  import ram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       arb_en,
  input  logic       req0,
  input  logic       req1,
  output logic       grant_valid,
  output logic       grant_id,
  output logic [2:0] starve_cnt
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic force_accel;

  always_comb begin
    force_accel = req1 && (starve_cnt == LIMIT);
    grant_valid = req0 || req1;
    grant_id    = (req1 && (!req0 || force_accel)) ? OWNER_ACCEL : OWNER_CORE;
  end

  // Only an IDLE arbitration moves the counter. With req1 high and the
  // accelerator not chosen, the core necessarily won that arbitration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 3'd0;
    end else if (arb_en) begin
      if (!req1 || (grant_id == OWNER_ACCEL)) begin
        starve_cnt <= 3'd0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares a single-port 1K x 32 RAM between the core (port 0) and the
// accelerator/DMA (port 1). Each access is arbitrated in IDLE, captured, and
// driven to the RAM from registers in ISSUE; reads return in RDATA.
//   clk, reset_n                 : clock, async active-low reset
//   req*/we*/addr*/wdata*/wmask* : requester ports, held until gnt*
//   gnt*                         : pulse in the cycle the access hits the RAM
//   rvalid*, rdata               : read return, rdata shared by both ports
//   ram_*                        : registered RAM IP pins, ram_rdata back
//   starve_cnt                   : debug view of the starvation counter
//
// state | meaning
// IDLE  | arbitrate sampled requests, capture the winner
// ISSUE | RAM pins active for the captured access, gnt pulse to owner
// RDATA | RAM read data on rdata, rvalid pulse to owner
//
// ADDR_W must equal RAM_ADDR_W; the captured request uses the package width.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = RAM_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  input  logic [3:0]        wmask0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  input  logic [3:0]        wmask1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wen,
  output logic              ram_rden,
  output logic [3:0]        ram_byteena,
  input  logic [31:0]       ram_rdata,
  output logic [2:0]        starve_cnt
);

  arb_state_t state_q, state_d;
  ram_req_t   req_q, sel;
  logic       owner_q;
  logic       arb_en, grant_valid, grant_id;

  assign arb_en = (state_q == IDLE);

  ram_arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_priority (
    .clk         (clk),
    .reset_n     (reset_n),
    .arb_en      (arb_en),
    .req0        (req0),
    .req1        (req1),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .starve_cnt  (starve_cnt)
  );

  // Read masks are dropped here so ram_byteena is already zero for reads.
  always_comb begin
    sel = '0;
    if (grant_id == OWNER_ACCEL) begin
      sel.we    = we1;
      sel.addr  = addr1;
      sel.wdata = wdata1;
      sel.wmask = we1 ? wmask1 : 4'b0000;
    end else begin
      sel.we    = we0;
      sel.addr  = addr0;
      sel.wdata = wdata0;
      sel.wmask = we0 ? wmask0 : 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = req_q.we ? IDLE : RDATA;
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture register doubles as the RAM drive: addr/wdata hold between
  // accesses, while the strobe and byte enables live for the ISSUE cycle only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q    <= '0;
      owner_q  <= OWNER_CORE;
      ram_wen  <= 1'b0;
      ram_rden <= 1'b0;
    end else begin
      ram_wen     <= 1'b0;
      ram_rden    <= 1'b0;
      req_q.wmask <= 4'b0000;
      if (arb_en && grant_valid) begin
        owner_q  <= grant_id;
        req_q    <= sel;
        ram_wen  <= sel.we;
        ram_rden <= !sel.we;
      end
    end
  end

  assign ram_addr    = req_q.addr;
  assign ram_wdata   = req_q.wdata;
  assign ram_byteena = req_q.wmask;

  always_comb begin
    gnt0    = (state_q == ISSUE) && (owner_q == OWNER_CORE);
    gnt1    = (state_q == ISSUE) && (owner_q == OWNER_ACCEL);
    rvalid0 = (state_q == RDATA) && (owner_q == OWNER_CORE);
    rvalid1 = (state_q == RDATA) && (owner_q == OWNER_ACCEL);
    rdata   = (state_q == RDATA) ? ram_rdata : 32'd0;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter for the single-port 1K x 32 on-chip RAM IP. It shares the RAM between the RISC-V core port (requester 0) and the PIM accelerator/DMA port (requester 1). Core has fixed priority, with a starvation counter that forces a grant to the accelerator. The block sits between both masters and the RAM IP's address, data, enable and byte-enable pins, and sequences every access through a small FSM.

## Interface
- `ADDR_W`, 10: RAM word-address width.
- `STARVE_LIMIT`, 4: consecutive core grants while req1 is pending before req1 is forced.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request; held until the matching `gnt` pulse.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  word address.
- `wdata0` / `wdata1`  in  32  write data.
- `wmask0` / `wmask1`  in  4  byte enables for writes; ignored on reads.
- `gnt0` / `gnt1`  out  1  one-cycle pulse in the cycle the access is issued to the RAM.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse; `rdata` is valid for that requester.
- `rdata`  out  32  read data shared by both requesters; qualify with `rvalid*`.
- `ram_addr`  out  ADDR_W  to RAM.
- `ram_wdata`  out  32  to RAM.
- `ram_wen`  out  1  to RAM.
- `ram_rden`  out  1  to RAM.
- `ram_byteena`  out  4  to RAM.
- `ram_rdata`  in  32  from RAM; valid one cycle after `ram_rden`.
- `starve_cnt`  out  3  debug view of the starvation counter.

## Operation
- States: IDLE, ISSUE, RDATA.
- **IDLE**
  - Arbitrate on the sampled `req0`/`req1`.
  - Winner: req0, unless req1 is pending and `starve_cnt == STARVE_LIMIT`.
  - Register the winner's owner id, we, addr, wdata and wmask, then go to ISSUE.
  - No request: stay in IDLE.
- **ISSUE**
  - Drive the RAM from the registered copy. `ram_wen` = we, `ram_rden` = !we, `ram_byteena` = we ? wmask : 4'b0000.
  - Pulse `gnt` for the owner.
  - Write: next state is IDLE. Read: next state is RDATA.
- **RDATA**
  - `rdata` = `ram_rdata`; pulse `rvalid` for the owner; go to IDLE.
- **Starvation counter**
  - Increments when the core is granted while req1 is high, saturating at STARVE_LIMIT.
  - Clears when req1 is granted or req1 is low in IDLE.
- A requester must hold its request stable from assertion until `gnt`. A request dropped before `gnt` is a protocol violation and the result is undefined.
- Writes with `wmask == 0` are still issued and granted; `ram_wen` = 1 with zero byte enables.

## Timing
- Reset values, applied asynchronously:
  - State IDLE.
  - All `gnt*`, `rvalid*`, `ram_wen`, `ram_rden` = 0.
  - `ram_byteena` = 0, `ram_addr` = 0, `ram_wdata` = 0.
  - `rdata` = 0, `starve_cnt` = 0.
- Latency from req rising at edge N (sampled in IDLE):
  - `gnt` high in cycle N+1.
  - Read `rvalid` high in cycle N+2.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Simultaneous req0 and req1 in IDLE: core wins unless the starvation limit is reached.
- The loser keeps its request high and is arbitrated on the next IDLE cycle.
- `ram_*` outputs are registered and change only on entering ISSUE. They return to wen = rden = 0 and byteena = 0 outside ISSUE; addr and wdata hold.
- Reset mid-access: the access is abandoned and no `gnt`/`rvalid` is produced. Masters must re-request after reset.

## Structure
- Shared package `ram_arb_pkg`:
  - typedef `arb_state_t` (IDLE, ISSUE, RDATA).
  - typedef `ram_req_t` struct: we, addr, wdata, wmask.
  - constant `RAM_RD_LAT = 1`.
- One sub-module: `ram_arb_priority`. It is the combinational winner select plus the saturating starvation counter.
- FSM, request capture register and RAM drive stay in the top module.

## Test plan
- Core write: addr 0x010, wdata 0xDEADBEEF, wmask 0xF -> `gnt0` at N+1 with `ram_wen` = 1, `ram_byteena` = 0xF, `ram_addr` = 0x010. A following read of 0x010 -> `rvalid0` at N+2 with `rdata` = 0xDEADBEEF.
- Partial write: wmask 0x3, wdata 0x0000ABCD over 0xDEADBEEF -> read back 0xDEADABCD.
- Simultaneous reads (req0 addr 0x001, req1 addr 0x002) -> `gnt0` first, `gnt1` on the next IDLE arbitration. Each `rvalid` carries its own word.
- req0 held continuously while req1 is pending -> after 4 core grants `starve_cnt` = 4 and the next grant is `gnt1`; the counter then returns to 0.
- Assert `reset_n` low during ISSUE of a read -> no `rvalid`, all outputs 0, state IDLE. A re-issued request completes normally.
- Write with wmask 0 -> `gnt` pulses, `ram_byteena` = 0, and memory contents are unchanged on read-back.
